// File: rtl/rename_checkpoint_ctrl_if.sv
// Rename-group, mapping-table and branch-resolution signals shared between
// the checkpoint scheduler (slave) and its environment (master).
interface rename_checkpoint_ctrl_if #(
   parameter int RENAME_WIDTH = 4,
   parameter int CP_IDX_W     = 2
);
   logic                    rename_valid;
   logic [RENAME_WIDTH-1:0] rename_slot_valid;
   logic [RENAME_WIDTH-1:0] rename_br;
   logic [RENAME_WIDTH-1:0] accept_mask;
   logic                    rename_ready;
   logic                    br_cp_valid;
   logic [CP_IDX_W-1:0]     br_cp_idx;
   logic                    mt_check;
   logic [CP_IDX_W-1:0]     mt_check_idx;
   logic                    mt_recover;
   logic [CP_IDX_W-1:0]     mt_recover_idx;
   logic                    mt_ready;
   logic                    resolve_valid;
   logic [CP_IDX_W-1:0]     resolve_idx;
   logic                    resolve_mispredict;
   logic [CP_IDX_W:0]       cp_free_count;
   logic                    recovering;

   modport master (
      output rename_valid, rename_slot_valid, rename_br, mt_ready,
             resolve_valid, resolve_idx, resolve_mispredict,
      input  accept_mask, rename_ready, br_cp_valid, br_cp_idx, mt_check,
             mt_check_idx, mt_recover, mt_recover_idx, cp_free_count, recovering
   );

   modport slave (
      input  rename_valid, rename_slot_valid, rename_br, mt_ready,
             resolve_valid, resolve_idx, resolve_mispredict,
      output accept_mask, rename_ready, br_cp_valid, br_cp_idx, mt_check,
             mt_check_idx, mt_recover, mt_recover_idx, cp_free_count, recovering
   );
endinterface

// File: rtl/rename_checkpoint_ctrl.sv
// Checkpoint scheduler for the rename mapping table: allocates checkpoints
// to branches in program order, frees them on resolve, sequences recovery.
module rename_checkpoint_ctrl #(
   parameter int RENAME_WIDTH = 4,
   parameter int CP_NUM       = 4,
   parameter int CP_IDX_W     = 2
) (
   input logic                     clock,
   input logic                     reset,
   rename_checkpoint_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_RECOVER = 2'd1, ST_WAIT = 2'd2} state_t;

   localparam logic [CP_IDX_W:0]       CP_FULL = (CP_IDX_W+1)'(CP_NUM);
   localparam logic [RENAME_WIDTH-1:0] ONE_RW  = RENAME_WIDTH'(1);

   state_t                  state_reg, state_next;
   logic [CP_IDX_W-1:0]     head_reg, head_next;
   logic [CP_IDX_W-1:0]     tail_reg, tail_next;
   logic [CP_IDX_W:0]       count_reg, count_next;
   logic [CP_NUM-1:0]       done_reg, done_next;
   logic                    recover_reg;
   logic [CP_IDX_W-1:0]     recover_idx_reg;

   logic [CP_IDX_W-1:0]     res_off;
   logic                    res_live, mispredict, correct;
   logic [RENAME_WIDTH-1:0] pend_br, low_br, below_br, accept;
   logic                    rename_active, alloc;
   logic [CP_NUM-1:0]       done_set, release_mask, younger_mask;
   logic [CP_IDX_W:0]       release_cnt;
   logic [CP_IDX_W-1:0]     walk_idx;
   logic                    chain;
   logic [CP_IDX_W-1:0]     ent_off [CP_NUM];

   // A resolve only matters when its checkpoint lies between head and tail.
   assign res_off    = bus.resolve_idx - head_reg;
   assign res_live   = bus.resolve_valid && ({1'b0, res_off} < count_reg);
   assign mispredict = res_live && bus.resolve_mispredict;
   assign correct    = res_live && !bus.resolve_mispredict;

   // Distance of every entry from head; entries at or past the mispredicted
   // one are the ones discarded by a recovery.
   generate
      for (genvar gi = 0; gi < CP_NUM; gi++) begin : g_ent
         assign ent_off[gi]      = CP_IDX_W'(gi) - head_reg;
         assign younger_mask[gi] = (ent_off[gi] >= res_off);
      end
   endgenerate

   // Oldest pending branch: everything up to it renames if a checkpoint is
   // free, otherwise only the slots in front of it.
   assign pend_br       = bus.rename_slot_valid & bus.rename_br;
   assign low_br        = pend_br & (~pend_br + ONE_RW);
   assign below_br      = low_br - ONE_RW;
   assign rename_active = (state_reg == ST_RUN) && bus.rename_valid && !mispredict;

   // Rename acceptance and checkpoint allocation for the current group.
   always_comb begin
      accept = '0;
      alloc  = 1'b0;
      if (rename_active) begin
         if (pend_br == '0) begin
            accept = bus.rename_slot_valid;
         end else if (count_reg != CP_FULL) begin
            accept = bus.rename_slot_valid & (low_br | below_br);
            alloc  = 1'b1;
         end else begin
            accept = bus.rename_slot_valid & below_br;
         end
      end
   end

   assign bus.accept_mask    = accept;
   assign bus.rename_ready   = rename_active && (accept == bus.rename_slot_valid);
   assign bus.br_cp_valid    = alloc;
   assign bus.br_cp_idx      = alloc ? tail_reg : '0;
   assign bus.mt_check       = alloc;
   assign bus.mt_check_idx   = alloc ? tail_reg : '0;
   assign bus.mt_recover     = recover_reg;
   assign bus.mt_recover_idx = recover_idx_reg;
   assign bus.cp_free_count  = CP_FULL - count_reg;
   assign bus.recovering     = (state_reg != ST_RUN);

   // Mark the resolving entry done, then release the contiguous done run at head.
   always_comb begin
      done_set = done_reg;
      if (correct) done_set[bus.resolve_idx] = 1'b1;
      release_mask = '0;
      release_cnt  = '0;
      chain        = 1'b1;
      walk_idx     = head_reg;
      for (int i = 0; i < CP_NUM; i++) begin
         walk_idx = head_reg + CP_IDX_W'(i);
         if (chain && ((CP_IDX_W+1)'(i) < count_reg) && done_set[walk_idx]) begin
            release_mask[walk_idx] = 1'b1;
            release_cnt            = release_cnt + 1'b1;
         end else begin
            chain = 1'b0;
         end
      end
   end

   // Pointer bookkeeping: a mispredict rewinds tail, otherwise net alloc/release.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      done_next  = done_reg;
      if (mispredict) begin
         tail_next  = bus.resolve_idx;
         count_next = {1'b0, res_off};
         done_next  = done_reg & ~younger_mask;
      end else begin
         done_next  = done_set & ~release_mask;
         head_next  = head_reg + release_cnt[CP_IDX_W-1:0];
         tail_next  = tail_reg + CP_IDX_W'(alloc);
         count_next = count_reg + (CP_IDX_W+1)'(alloc) - release_cnt;
      end
   end

   // Recovery sequencing; a mispredict restarts it from any state.
   always_comb begin
      state_next = state_reg;
      if (mispredict) begin
         state_next = ST_RECOVER;
      end else begin
         case (state_reg)
            ST_RUN:     state_next = ST_RUN;
            ST_RECOVER: state_next = ST_WAIT;
            ST_WAIT:    if (bus.mt_ready) state_next = ST_RUN;
            default:    state_next = ST_RUN;
         endcase
      end
   end

   // State and checkpoint ring registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_RUN;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         done_reg  <= '0;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         done_reg  <= done_next;
      end
   end

   // Registered recover pulse and index toward the mapping table.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         recover_reg     <= 1'b0;
         recover_idx_reg <= '0;
      end else begin
         recover_reg <= mispredict;
         if (mispredict) recover_idx_reg <= bus.resolve_idx;
      end
   end
endmodule

// File: tb/tb_rename_checkpoint_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against an in-order queue model of outstanding checkpoints.
module tb_rename_checkpoint_ctrl;
   localparam int RW = 4;
   localparam int CPN = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   rename_checkpoint_ctrl_if #(.RENAME_WIDTH(RW), .CP_IDX_W(2)) bus_if ();

   rename_checkpoint_ctrl #(.RENAME_WIDTH(RW), .CP_NUM(CPN), .CP_IDX_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_cyc    = 0;

   // model: outstanding checkpoints in program order
   int   q_idx[$];
   bit   q_done[$];
   int   alloc_ptr;
   bit   m_rec_pulse, m_wait;
   int   m_rec_idx;

   logic [RW-1:0] e_acc;
   bit            e_alloc, e_mp, e_ready;
   int            e_pos;

   logic [RW-1:0] obs_acc;
   logic          obs_ready, obs_check, obs_rec, obs_recov;
   logic [1:0]    obs_idx, obs_rec_idx;
   logic [2:0]    obs_free;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, n_cyc);
      end
   endtask

   task automatic model_reset();
      q_idx.delete();
      q_done.delete();
      alloc_ptr   = 0;
      m_rec_pulse = 1'b0;
      m_wait      = 1'b0;
      m_rec_idx   = 0;
   endtask

   task automatic do_cycle(input bit v, input logic [RW-1:0] p, input logic [RW-1:0] br,
                           input bit rv, input int ridx, input bit rmp, input bit rdy);
      bit run, stop;
      bus_if.rename_valid       = v;
      bus_if.rename_slot_valid  = p;
      bus_if.rename_br          = br;
      bus_if.resolve_valid      = rv;
      bus_if.resolve_idx        = 2'(ridx);
      bus_if.resolve_mispredict = rmp;
      bus_if.mt_ready           = rdy;
      @(negedge clock);
      n_cyc++;
      e_pos = -1;
      if (rv) foreach (q_idx[i]) if (q_idx[i] == ridx) e_pos = i;
      e_mp    = (e_pos >= 0) && rmp;
      run     = !m_rec_pulse && !m_wait;
      e_acc   = '0;
      e_alloc = 1'b0;
      stop    = 1'b0;
      if (run && v && !e_mp) begin
         for (int i = 0; i < RW; i++) begin
            if (!stop && p[i]) begin
               if (br[i]) begin
                  if (q_idx.size() < CPN) begin
                     e_acc[i] = 1'b1;
                     e_alloc  = 1'b1;
                  end
                  stop = 1'b1;
               end else begin
                  e_acc[i] = 1'b1;
               end
            end
         end
      end
      e_ready     = run && v && !e_mp && (e_acc == p);
      obs_acc     = bus_if.accept_mask;
      obs_ready   = bus_if.rename_ready;
      obs_check   = bus_if.mt_check;
      obs_idx     = bus_if.br_cp_idx;
      obs_rec     = bus_if.mt_recover;
      obs_rec_idx = bus_if.mt_recover_idx;
      obs_free    = bus_if.cp_free_count;
      obs_recov   = bus_if.recovering;
      check_val("accept_mask", obs_acc, e_acc);
      check_val("rename_ready", obs_ready, e_ready);
      check_val("br_cp_valid", bus_if.br_cp_valid, e_alloc);
      check_val("br_cp_idx", obs_idx, e_alloc ? alloc_ptr : 0);
      check_val("mt_check", obs_check, e_alloc);
      check_val("mt_check_idx", bus_if.mt_check_idx, e_alloc ? alloc_ptr : 0);
      check_val("mt_recover", obs_rec, m_rec_pulse);
      check_val("mt_recover_idx", obs_rec_idx, m_rec_idx);
      check_val("cp_free_count", obs_free, CPN - q_idx.size());
      check_val("recovering", obs_recov, m_rec_pulse || m_wait);
      $display("cyc %0d v=%b p=%b br=%b res=%b/%0d/%b acc=%b rdy=%b chk=%b idx=%0d rec=%b free=%0d",
               n_cyc, v, p, br, rv, ridx, rmp, obs_acc, obs_ready, obs_check, obs_idx, obs_rec, obs_free);
      @(posedge clock);
      if (e_mp) begin
         while (q_idx.size() > e_pos) begin
            void'(q_idx.pop_back());
            void'(q_done.pop_back());
         end
         alloc_ptr   = ridx;
         m_rec_pulse = 1'b1;
         m_wait      = 1'b0;
         m_rec_idx   = ridx;
      end else begin
         if (e_pos >= 0) q_done[e_pos] = 1'b1;
         if (e_alloc) begin
            q_idx.push_back(alloc_ptr);
            q_done.push_back(1'b0);
            alloc_ptr = (alloc_ptr + 1) % CPN;
         end
         while (q_idx.size() > 0 && q_done[0]) begin
            void'(q_idx.pop_front());
            void'(q_done.pop_front());
         end
         if (m_rec_pulse) begin
            m_rec_pulse = 1'b0;
            m_wait      = 1'b1;
         end else if (m_wait && rdy) begin
            m_wait = 1'b0;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      reset                     = 1'b0;
      bus_if.rename_valid       = 1'b0;
      bus_if.rename_slot_valid  = '0;
      bus_if.rename_br          = '0;
      bus_if.resolve_valid      = 1'b0;
      bus_if.resolve_idx        = '0;
      bus_if.resolve_mispredict = 1'b0;
      bus_if.mt_ready           = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_val("rst_accept", bus_if.accept_mask, 0);
      check_val("rst_ready", bus_if.rename_ready, 0);
      check_val("rst_check", bus_if.mt_check, 0);
      check_val("rst_recover", bus_if.mt_recover, 0);
      check_val("rst_free", bus_if.cp_free_count, CPN);
      check_val("rst_recovering", bus_if.recovering, 0);
      $display("reset applied");
      reset = 1'b1;
   endtask

   logic [RW-1:0] grp_p, grp_br;
   int            ridx;

   initial begin
      apply_reset();

      // 1: group without branches
      do_cycle(1, 4'b1111, 4'b0000, 0, 0, 0, 0);
      check_val("t1_acc", obs_acc, 4'b1111);
      check_val("t1_ready", obs_ready, 1);
      check_val("t1_free", obs_free, 4);

      // 2: branch in slot 2 splits the group
      do_cycle(1, 4'b1111, 4'b0100, 0, 0, 0, 0);
      check_val("t2_acc", obs_acc, 4'b0111);
      check_val("t2_check", obs_check, 1);
      check_val("t2_idx", obs_idx, 0);
      check_val("t2_ready", obs_ready, 0);
      do_cycle(1, 4'b1000, 4'b0000, 0, 0, 0, 0);
      check_val("t2b_acc", obs_acc, 4'b1000);
      check_val("t2b_ready", obs_ready, 1);
      check_val("t2b_free", obs_free, 3);

      // 3: fill all checkpoints, then stall on a full table
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
         check_val("t3_idx", obs_idx, i);
      end
      do_cycle(1, 4'b1111, 4'b0010, 0, 0, 0, 0);
      check_val("t3_free", obs_free, 0);
      check_val("t3_acc_partial", obs_acc, 4'b0001);
      check_val("t3_nocheck", obs_check, 0);
      do_cycle(1, 4'b1111, 4'b0001, 0, 0, 0, 0);
      check_val("t3_acc_zero", obs_acc, 4'b0000);

      // 4: out-of-order resolve, then in-order release with wrap
      do_cycle(0, 4'b0000, 4'b0000, 1, 1, 0, 0);
      do_cycle(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
      check_val("t4_free_held", obs_free, 0);
      do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      check_val("t4_free", obs_free, 2);
      check_val("t4_wrap_idx", obs_idx, 0);

      // 5: mispredict on checkpoint 1
      apply_reset();
      for (int i = 0; i < 4; i++) do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      do_cycle(1, 4'b0001, 4'b0001, 1, 1, 1, 0);
      check_val("t5_mp_stall", obs_acc, 0);
      do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      check_val("t5_recover", obs_rec, 1);
      check_val("t5_recover_idx", obs_rec_idx, 1);
      check_val("t5_stall", obs_acc, 0);
      do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      check_val("t5_pulse_end", obs_rec, 0);
      do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 1);
      do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      check_val("t5_free", obs_free, 3);
      check_val("t5_idx", obs_idx, 1);

      // 6: reset while waiting for the table
      for (int i = 0; i < 2; i++) do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      do_cycle(0, 4'b0000, 4'b0000, 1, 2, 1, 0);
      do_cycle(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      do_cycle(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      check_val("t6_recover", bus_if.mt_recover, 0);
      check_val("t6_recovering", bus_if.recovering, 0);
      check_val("t6_free", bus_if.cp_free_count, CPN);
      apply_reset();
      do_cycle(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
      check_val("t6_idx", obs_idx, 0);

      // random traffic with upstream re-presenting unaccepted slots
      grp_p  = 4'($urandom);
      grp_br = 4'($urandom);
      for (int c = 0; c < 400; c++) begin
         if (q_idx.size() > 0 && $urandom_range(0, 9) < 7)
            ridx = q_idx[$urandom_range(0, q_idx.size() - 1)];
         else
            ridx = $urandom_range(0, 3);
         do_cycle($urandom_range(0, 9) < 8, grp_p, grp_br,
                  $urandom_range(0, 9) < 4, ridx, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 4);
         if (e_ready) begin
            grp_p  = 4'($urandom);
            grp_br = 4'($urandom);
         end else begin
            grp_p = grp_p & ~e_acc;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/rename_checkpoint_ctrl.md
Name: rename_checkpoint_ctrl

Overview:
Checkpoint scheduler for the rename-stage mapping table. It allocates RAT checkpoint slots to branches in program order and drives the table's check/check_idx port in the same cycle the branch is renamed. It releases checkpoints when branches resolve, sequences recover/recover_idx on a mispredict, and stalls rename while checkpoints are exhausted or recovery is in progress.

Parameters:
RENAME_WIDTH, 4, rename slots per group (slot 0 oldest)
CP_NUM, 4, number of mapping-table checkpoints (power of 2)
CP_IDX_W, 2, log2(CP_NUM)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
rename_valid  in  1  rename group present
rename_slot_valid  in  RENAME_WIDTH  slots of the group still pending
rename_br  in  RENAME_WIDTH  pending slot is a branch needing a checkpoint
accept_mask  out  RENAME_WIDTH  slots renamed this cycle (combinational)
rename_ready  out  1  whole pending group consumed this cycle
br_cp_valid  out  1  an accepted slot is a branch this cycle
br_cp_idx  out  CP_IDX_W  checkpoint assigned to that branch
mt_check  out  1  to mapping table check
mt_check_idx  out  CP_IDX_W  to mapping table check_idx
mt_recover  out  1  to mapping table recover (registered)
mt_recover_idx  out  CP_IDX_W  to mapping table recover_idx (registered)
mt_ready  in  1  mapping table ready after recovery
resolve_valid  in  1  branch resolution
resolve_idx  in  CP_IDX_W  checkpoint of the resolving branch
resolve_mispredict  in  1  resolution is a mispredict
cp_free_count  out  CP_IDX_W+1  free checkpoints
recovering  out  1  state is not RUN

Behaviour:
- State: head, tail (circular, CP_IDX_W bits, wrap CP_NUM-1 -> 0), count (0..CP_NUM), done[CP_NUM], FSM {RUN, RECOVER, WAIT}.
- Reset (async, low): head=tail=count=0, done=0, FSM=RUN, mt_recover=0, mt_recover_idx=0. cp_free_count=CP_NUM. All combinational outputs are 0 with no input.
- RUN, rename_valid=1, no resolve_mispredict, with p = rename_slot_valid:
  - If p&rename_br == 0: accept_mask=p.
  - Otherwise f = lowest set bit of p&rename_br.
    - If count<CP_NUM: accept_mask = p & bits[0..f]; mt_check=br_cp_valid=1; mt_check_idx=br_cp_idx=tail; at the edge tail++ and count++.
    - If full: accept_mask = p & bits[0..f-1], which is 0 when f=0; no check.
  - rename_ready = (accept_mask==p). Upstream re-presents the unaccepted slots.
  - At most one checkpoint is allocated per cycle. The snapshot taken at the edge includes the branch's own rename.
- Correct resolve: valid only if idx is in flight (between head and tail-1 circularly with count>0); otherwise ignored.
  - Sets done[idx].
  - At the same edge, head advances over all contiguous done entries, clearing their done bits. count decreases accordingly, up to CP_NUM per cycle.
- Mispredict with idx in flight, in any state:
  - Next edge: FSM=RECOVER, mt_recover_idx=idx.
  - tail=idx; count=(idx-head) mod CP_NUM. idx and all younger entries are freed and their done bits cleared.
  - A mispredict on a non-in-flight idx is ignored.
- RECOVER: mt_recover=1 for exactly this one cycle. Next edge goes to WAIT.
- WAIT: when mt_ready=1, go to RUN at the next edge.
- In RECOVER and WAIT: accept_mask=0, rename_ready=0, mt_check=0.
- In the mispredict cycle itself, rename is stalled (accept_mask=0, no check); the mispredict wins over allocation.
- Correct resolves of still-in-flight entries are processed in every state.
- A new mispredict on an in-flight (older) entry during RECOVER/WAIT re-enters RECOVER with the new idx.
- Allocation, correct resolve and head release may occur in the same cycle. count is updated by the net change.
- cp_free_count = CP_NUM - count.

Test Plan:
1. Reset, then slot_valid=1111, br=0000 -> accept=1111, rename_ready=1, mt_check=0, free=4.
2. slot_valid=1111, br=0100 -> accept=0111, mt_check=1, idx=0, ready=0. Next cycle slot_valid=1000, br=0 -> accept=1000, ready=1, free=3.
3. Four single-branch groups (br=0001) -> idx 0,1,2,3, free=0. Then br=0010 with slot_valid=1111 -> accept=0001, no check. Then br=0001 -> accept=0000.
4. With 0..3 in flight: resolve 1 correct -> free stays 0. Resolve 0 correct -> next cycle free=2, head=2. Next allocation gets idx 0 (wrap).
5. With 0..3 in flight: mispredict idx 1 -> next cycle mt_recover=1, idx=1 for one cycle. Rename stalled while mt_ready=0. After mt_ready=1, RUN; free=3; next branch gets idx 1.
6. Assert reset during WAIT -> immediately mt_recover=0, recovering=0, free=4. First branch after release gets idx 0.
